// File: rtl/writeback_unit_if.sv
// writeback_unit_if: execute/memory-side inputs and register-file/forwarding outputs of the writeback stage
//   master : execute + data memory side (drives instruction and load-return inputs)
//   slave  : writeback_unit (drives in_ready, regfile write, forwarding, busy, err)
interface writeback_unit_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_kind;
   logic [ADDR_W-1:0] in_rd;
   logic [DATA_W-1:0] in_alu;
   logic [DATA_W-1:0] in_imm;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              wen;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic              fwd_valid;
   logic [ADDR_W-1:0] fwd_addr;
   logic [DATA_W-1:0] fwd_data;
   logic              busy;
   logic              err;

   modport master (
      output in_valid, in_kind, in_rd, in_alu, in_imm, mem_rdata, mem_rvalid,
      input  in_ready, wen, write_addr, write_data, fwd_valid, fwd_addr, fwd_data, busy, err
   );

   modport slave (
      input  in_valid, in_kind, in_rd, in_alu, in_imm, mem_rdata, mem_rvalid,
      output in_ready, wen, write_addr, write_data, fwd_valid, fwd_addr, fwd_data, busy, err
   );
endinterface

// File: rtl/writeback_unit.sv
// writeback_unit: retires ALU/immediate/load results into the register file, stalling on loads
//   clk   : clock, all state on posedge
//   rst_n : synchronous active-low reset
//   bus   : writeback_unit_if.slave (instruction in, load return in, regfile write out,
//           forwarding out, busy, sticky load-timeout err)
//   Optional macro WB_FWD_EN: when defined, the forwarding port mirrors the registered
//   write; otherwise it is tied to zero.
module writeback_unit #(
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 8,
   parameter int MEM_TIMEOUT = 8
) (
   input logic               clk,
   input logic               rst_n,
   writeback_unit_if.slave   bus
);
   typedef enum logic {IDLE, WAIT_MEM} state_t;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      wen_d   = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      if (state_q == IDLE) begin
         if (bus.in_valid && bus.in_kind == 2'b10) begin
            rd_d    = bus.in_rd;
            cnt_d   = '0;
            state_d = WAIT_MEM;
         end else if (bus.in_valid && bus.in_kind != 2'b00) begin
            wen_d  = 1'b1;
            addr_d = bus.in_rd;
            data_d = bus.in_kind[1] ? bus.in_imm : bus.in_alu;
         end
      end else if (bus.mem_rvalid) begin
         // returning data beats a coincident timeout
         wen_d   = 1'b1;
         addr_d  = rd_q;
         data_d  = bus.mem_rdata;
         state_d = IDLE;
      end else if (cnt_q == CNT_LAST) begin
         err_d   = 1'b1;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q == WAIT_MEM);
   assign bus.wen        = wen_q;
   assign bus.write_addr = addr_q;
   assign bus.write_data = data_q;
   assign bus.err        = err_q;

`ifdef WB_FWD_EN
   assign bus.fwd_valid = wen_q;
   assign bus.fwd_addr  = addr_q;
   assign bus.fwd_data  = data_q;
`else
   assign bus.fwd_valid = 1'b0;
   assign bus.fwd_addr  = '0;
   assign bus.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed scoreboard bench for writeback_unit (MEM_TIMEOUT = 4)
module tb_writeback_unit;
   localparam int ADDR_W = 4;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   writeback_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   writeback_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic due = 1'b0;
   logic exp_err = 1'b0;
   logic [ADDR_W+DATA_W-1:0] sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input logic exp_busy);
      logic [ADDR_W+DATA_W-1:0] e;
      @(posedge clk);
      #1;
      chk("wen", 32'(bus.wen), 32'(due));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("in_ready", 32'(bus.in_ready), 32'(!exp_busy));
      chk("err", 32'(bus.err), 32'(exp_err));
      if (due) begin
         if (sb.size() == 0) chk("sb_size", 32'(sb.size()), 32'd1);
         else begin
            e = sb.pop_front();
            chk("write_addr", 32'(bus.write_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            chk("write_data", 32'(bus.write_data), 32'(e[DATA_W-1:0]));
         end
      end
`ifdef WB_FWD_EN
      chk("fwd_valid", 32'(bus.fwd_valid), 32'(due));
      if (due) begin
         chk("fwd_addr", 32'(bus.fwd_addr), 32'(bus.write_addr));
         chk("fwd_data", 32'(bus.fwd_data), 32'(bus.write_data));
      end
`else
      chk("fwd_off", 32'({bus.fwd_valid, bus.fwd_addr, bus.fwd_data}), 32'd0);
`endif
   endtask

   task automatic drive(input logic v, input logic [1:0] k, input logic [ADDR_W-1:0] rd,
                        input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] imm);
      bus.in_valid = v;
      bus.in_kind  = k;
      bus.in_rd    = rd;
      bus.in_alu   = alu;
      bus.in_imm   = imm;
   endtask

   initial begin
      drive(1'b0, 2'b00, '0, '0, '0);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      // reset for two cycles
      tick(1'b0);
      tick(1'b0);
      chk("rst_addr", 32'(bus.write_addr), 32'd0);
      chk("rst_data", 32'(bus.write_data), 32'd0);
      rst_n = 1'b1;
      // ALU retire
      drive(1'b1, 2'b01, 4'd3, 8'h5A, 8'h00);
      sb.push_back({4'd3, 8'h5A});
      due = 1'b1;
      tick(1'b0);
      drive(1'b0, 2'b00, '0, '0, '0);
      due = 1'b0;
      tick(1'b0);
      // no-write kind
      drive(1'b1, 2'b00, 4'd4, 8'h44, 8'h44);
      tick(1'b0);
      drive(1'b0, 2'b00, '0, '0, '0);
      tick(1'b0);
      // back-to-back immediate then ALU
      drive(1'b1, 2'b11, 4'd1, 8'hEE, 8'h11);
      sb.push_back({4'd1, 8'h11});
      due = 1'b1;
      tick(1'b0);
      drive(1'b1, 2'b01, 4'd2, 8'h22, 8'hDD);
      sb.push_back({4'd2, 8'h22});
      tick(1'b0);
      drive(1'b0, 2'b00, '0, '0, '0);
      due = 1'b0;
      tick(1'b0);
      // load with rvalid three WAIT_MEM cycles later
      drive(1'b1, 2'b10, 4'd7, 8'h00, 8'h00);
      tick(1'b1);
      drive(1'b1, 2'b01, 4'd15, 8'hBB, 8'h00);
      tick(1'b1);
      tick(1'b1);
      drive(1'b0, 2'b00, '0, '0, '0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 8'hC3;
      sb.push_back({4'd7, 8'hC3});
      due = 1'b1;
      tick(1'b0);
      bus.mem_rvalid = 1'b0;
      due = 1'b0;
      tick(1'b0);
      // rvalid coincides with the timeout edge: write wins, no err
      drive(1'b1, 2'b10, 4'd4, 8'h00, 8'h00);
      tick(1'b1);
      drive(1'b0, 2'b00, '0, '0, '0);
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 8'h3C;
      sb.push_back({4'd4, 8'h3C});
      due = 1'b1;
      tick(1'b0);
      bus.mem_rvalid = 1'b0;
      due = 1'b0;
      // load timeout after 4 WAIT_MEM cycles
      drive(1'b1, 2'b10, 4'd5, 8'h00, 8'h00);
      tick(1'b1);
      drive(1'b0, 2'b00, '0, '0, '0);
      tick(1'b1);
      tick(1'b1);
      tick(1'b1);
      exp_err = 1'b1;
      tick(1'b0);
      tick(1'b0);
      drive(1'b1, 2'b01, 4'd5, 8'h55, 8'h00);
      sb.push_back({4'd5, 8'h55});
      due = 1'b1;
      tick(1'b0);
      drive(1'b0, 2'b00, '0, '0, '0);
      due = 1'b0;
      tick(1'b0);
      // reset in the 2nd WAIT_MEM cycle, then rvalid in IDLE
      drive(1'b1, 2'b10, 4'd6, 8'h00, 8'h00);
      tick(1'b1);
      drive(1'b0, 2'b00, '0, '0, '0);
      tick(1'b1);
      rst_n = 1'b0;
      exp_err = 1'b0;
      tick(1'b0);
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 8'h99;
      tick(1'b0);
      tick(1'b0);
      bus.mem_rvalid = 1'b0;
      // forwarding candidate write
      drive(1'b1, 2'b01, 4'd9, 8'hFE, 8'h00);
      sb.push_back({4'd9, 8'hFE});
      due = 1'b1;
      tick(1'b0);
      drive(1'b0, 2'b00, '0, '0, '0);
      due = 1'b0;
      tick(1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writeback stage directly upstream of the register file; produces its `wen`, `write_addr` and `write_data` inputs.
- Accepts one retiring instruction per cycle from execute: ALU result, immediate move, load, or no-write.
- Loads stall the stage until data memory returns data or a timeout fires.
- Drives a forwarding port so the decode stage can bypass the write that lands at the next clock edge.

Parameters:
- ADDR_W, 4, register-file address width; must equal the register file's address width.
- DATA_W, 8, datapath width.
- MEM_TIMEOUT, 8, maximum cycles spent in WAIT_MEM before a load is abandoned; legal range 2..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept; transfer occurs when in_valid & in_ready are high at a posedge.
- in_kind  in  2  00 = no-write, 01 = ALU, 10 = load, 11 = immediate.
- in_rd  in  ADDR_W  destination register.
- in_alu  in  DATA_W  ALU result.
- in_imm  in  DATA_W  immediate value.
- mem_rdata  in  DATA_W  load data.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- wen  out  1  register-file write enable.
- write_addr  out  ADDR_W  register-file write pointer.
- write_data  out  DATA_W  register-file write data.
- fwd_valid  out  1  forwarding entry valid.
- fwd_addr  out  ADDR_W  forwarded register.
- fwd_data  out  DATA_W  forwarded value.
- busy  out  1  high while in WAIT_MEM.
- err  out  1  sticky load-timeout flag.

Behaviour:
- All outputs are registered except `in_ready` and `busy`, which decode the state, and the forwarding port.
- Reset (rst_n = 0 at a posedge):
  - state goes to IDLE.
  - wen, write_addr, write_data, err and the timeout counter clear to 0.
  - the pending rd register clears to 0.
  - No write is issued in the cycle after reset, even if reset hits mid-load.
- States: IDLE and WAIT_MEM.
  - in_ready = (state == IDLE).
  - busy = (state == WAIT_MEM).
- IDLE, accept at edge N:
  - kind 01: wen = 1, write_addr = in_rd, write_data = in_alu during cycle N+1. The register file commits at edge N+1.
  - kind 11: same as kind 01, with write_data = in_imm.
  - kind 00: wen = 0 in cycle N+1; instruction retired.
  - kind 10: latch in_rd; go to WAIT_MEM; counter = 0; wen = 0.
- IDLE, no accept: wen = 0 next cycle. wen is a single-cycle pulse per write.
- Back-to-back ALU/immediate accepts produce wen high on consecutive cycles, each carrying its own address and data.
- WAIT_MEM, mem_rvalid = 1 at edge M:
  - wen = 1, write_addr = latched rd, write_data = mem_rdata during cycle M+1.
  - go to IDLE, so in_ready is high in cycle M+1.
- WAIT_MEM, no rvalid: counter increments.
  - If counter == MEM_TIMEOUT-1 at an edge without rvalid: go to IDLE, err = 1, no write.
  - If rvalid and the timeout condition occur at the same edge, rvalid wins and a normal write occurs.
- mem_rvalid while in IDLE is ignored.
- in_valid while in WAIT_MEM is not accepted; execute holds its inputs.
- err stays high until reset. It does not block further operation.
- All arithmetic is unsigned. The counter is 8 bits wide. No data is modified, only routed.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined:
  - fwd_valid = wen, fwd_addr = write_addr, fwd_data = write_data, combinationally from the output registers.
  - Decode can then bypass a register whose write lands at the coming edge.
- Undefined:
  - fwd_valid, fwd_addr and fwd_data are tied to 0.
  - No forwarding logic is synthesised.
  - All other behaviour is identical.

Test Plan:
- Reset then ALU retire: rst_n low 2 cycles, then accept kind 01, rd = 3, in_alu = 0x5A -> wen = 1, write_addr = 3, write_data = 0x5A for exactly one cycle after accept; wen = 0 otherwise.
- Back-to-back writes: accept immediate rd = 1 imm = 0x11, then ALU rd = 2 alu = 0x22 on consecutive edges -> wen high 2 consecutive cycles, (1, 0x11) then (2, 0x22).
- Load with latency: accept kind 10, rd = 7; mem_rvalid with rdata = 0xC3 three cycles later -> busy and in_ready = 0 for 3 cycles; next cycle wen = 1, addr = 7, data = 0xC3; in_ready = 1 in that same cycle.
- Load timeout: MEM_TIMEOUT = 4, accept load rd = 5, never assert rvalid -> return to IDLE after 4 WAIT_MEM cycles, err = 1, no wen; a later ALU write to rd = 5 still occurs.
- Reset mid-load and stray rvalid:
  - Reset mid-load: accept load, pulse rst_n low at the 2nd WAIT_MEM cycle, then raise rvalid -> IDLE, no write, err = 0.
  - Stray rvalid: rvalid in IDLE -> no write.
- Forwarding: with WB_FWD_EN, ALU rd = 9, data = 0xFE -> fwd_valid = 1, fwd_addr = 9, fwd_data = 0xFE in the same cycle as wen. Without the macro, fwd_* stay 0 for the whole test.
